// File: rtl/adc_frame_packer.sv
// adc_frame_packer: decimates a raw ADC stream and packs it into framed
// bursts (header, sample count, samples, optional checksum) for the 16-bit
// capture FIFO feeding the MBED SPI master.
// Optional feature macro: CHECKSUM_EN (adds the TRL checksum trailer word).
module adc_frame_packer #(
  parameter int unsigned ADC_BITS  = 12,
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned DECIM     = 1,
  parameter logic [7:0]  HDR_TAG   = 8'hA5
) (
  input  logic                SYS_CLK,
  input  logic                reset_n,
  input  logic                ARM,
  input  logic [ADC_BITS-1:0] ADC_DATA,
  input  logic                ADC_VALID,
  input  logic                FIFO_FULL,
  output logic                FIFO_WR,
  output logic [15:0]         FIFO_DIN,
  output logic                BUSY,
  output logic                DONE,
  output logic                OVERFLOW,
  output logic [15:0]         FRAME_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    SMP,
`ifdef CHECKSUM_EN
    TRL,
`endif
    DONE_ST
  } state_t;

  state_t state_q, state_d;

  logic        arm_q;
  logic        arm_edge;
  logic [7:0]  dec_q, dec_d;
  logic [15:0] smp_q, smp_d;
  logic        wr_d;
  logic [15:0] din_d;
  logic        busy_d;
  logic        done_d;
  logic        ovf_d;
  logic [15:0] fcnt_d;
`ifdef CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic signed [ADC_BITS-1:0] adc_s;
  logic [15:0]                adc_ext;

  assign adc_s    = ADC_DATA;
  assign adc_ext  = 16'(adc_s);
  assign arm_edge = ARM & ~arm_q;

  // State register.
  always_ff @(posedge SYS_CLK) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-output decode; every output is registered below so
  // a word chosen in this cycle reaches the FIFO on the next one.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    smp_d   = smp_q;
    wr_d    = 1'b0;
    din_d   = FIFO_DIN;
    busy_d  = BUSY;
    done_d  = 1'b0;
    ovf_d   = OVERFLOW;
    fcnt_d  = FRAME_CNT;
`ifdef CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (arm_edge) begin
          state_d = HDR;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          smp_d   = '0;
          dec_d   = '0;
`ifdef CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR: begin
        if (!FIFO_FULL) begin
          wr_d    = 1'b1;
          din_d   = {HDR_TAG, FRAME_CNT[7:0]};
          state_d = CNT;
        end
      end
      CNT: begin
        if (!FIFO_FULL) begin
          wr_d    = 1'b1;
          din_d   = 16'(N_SAMPLES);
          state_d = SMP;
          dec_d   = '0;
          smp_d   = '0;
        end
      end
      SMP: begin
        if (ADC_VALID) begin
          dec_d = (dec_q == 8'(DECIM - 1)) ? '0 : dec_q + 8'd1;
          if (dec_q == '0) begin
            // A kept sample counts toward the frame even if it is dropped.
            if (!FIFO_FULL) begin
              wr_d   = 1'b1;
              din_d  = adc_ext;
`ifdef CHECKSUM_EN
              csum_d = csum_q + adc_ext;
`endif
            end else begin
              ovf_d = 1'b1;
            end
            smp_d = smp_q + 16'd1;
            if (smp_q == 16'(N_SAMPLES - 1)) begin
`ifdef CHECKSUM_EN
              state_d = TRL;
`else
              state_d = DONE_ST;
`endif
            end
          end
        end
      end
`ifdef CHECKSUM_EN
      TRL: begin
        if (!FIFO_FULL) begin
          wr_d    = 1'b1;
          din_d   = csum_q;
          state_d = DONE_ST;
        end
      end
`endif
      DONE_ST: begin
        done_d  = 1'b1;
        fcnt_d  = FRAME_CNT + 16'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge SYS_CLK) begin
    if (!reset_n) begin
      arm_q     <= 1'b0;
      dec_q     <= '0;
      smp_q     <= '0;
      FIFO_WR   <= 1'b0;
      FIFO_DIN  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OVERFLOW  <= 1'b0;
      FRAME_CNT <= '0;
`ifdef CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      arm_q     <= ARM;
      dec_q     <= dec_d;
      smp_q     <= smp_d;
      FIFO_WR   <= wr_d;
      FIFO_DIN  <= din_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      OVERFLOW  <= ovf_d;
      FRAME_CNT <= fcnt_d;
`ifdef CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: scoreboard bench for adc_frame_packer. Expected FIFO
// words are queued as stimulus is driven and popped as writes appear.
module tb_adc_frame_packer;

  logic        SYS_CLK = 1'b0;
  logic        reset_n;
  logic        arm, adc_valid, fifo_full;
  logic [11:0] adc_data;
  logic        fifo_wr, busy, done, overflow;
  logic [15:0] fifo_din, frame_cnt;

  logic        b_arm, b_valid, b_full;
  logic [11:0] b_data;
  logic        b_wr, b_busy, b_done, b_ovf;
  logic [15:0] b_din, b_fcnt;

  logic [15:0] expq[$];
  logic [15:0] expq_b[$];
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  adc_frame_packer #(.ADC_BITS(12), .N_SAMPLES(4), .DECIM(1), .HDR_TAG(8'hA5)) dut (
    .SYS_CLK(SYS_CLK), .reset_n(reset_n), .ARM(arm), .ADC_DATA(adc_data),
    .ADC_VALID(adc_valid), .FIFO_FULL(fifo_full), .FIFO_WR(fifo_wr),
    .FIFO_DIN(fifo_din), .BUSY(busy), .DONE(done), .OVERFLOW(overflow),
    .FRAME_CNT(frame_cnt)
  );

  adc_frame_packer #(.ADC_BITS(12), .N_SAMPLES(2), .DECIM(3), .HDR_TAG(8'hA5)) dut_b (
    .SYS_CLK(SYS_CLK), .reset_n(reset_n), .ARM(b_arm), .ADC_DATA(b_data),
    .ADC_VALID(b_valid), .FIFO_FULL(b_full), .FIFO_WR(b_wr),
    .FIFO_DIN(b_din), .BUSY(b_busy), .DONE(b_done), .OVERFLOW(b_ovf),
    .FRAME_CNT(b_fcnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard for the main instance.
  always begin : mon_a
    logic [15:0] w;
    @(posedge SYS_CLK);
    #1;
    if (fifo_wr) begin
      if (expq.size() == 0) check_val("extra_wr_a", 32'(fifo_wr), 32'd0);
      else begin
        w = expq.pop_front();
        check_val("word_a", 32'(fifo_din), 32'(w));
      end
    end
  end

  // Scoreboard for the decimating instance.
  always begin : mon_b
    logic [15:0] w;
    @(posedge SYS_CLK);
    #1;
    if (b_wr) begin
      if (expq_b.size() == 0) check_val("extra_wr_b", 32'(b_wr), 32'd0);
      else begin
        w = expq_b.pop_front();
        check_val("word_b", 32'(b_din), 32'(w));
      end
    end
  end

  task automatic run_frame(input logic [11:0] s0, input logic [11:0] s1,
                           input logic [11:0] s2, input logic [11:0] s3,
                           input logic [3:0] drop, input int stall, input bit toggle);
    logic [11:0] s[4];
    logic [15:0] w;
    logic [15:0] sum;
    int ndone;
    s   = '{s0, s1, s2, s3};
    sum = '0;
    expq.push_back({8'hA5, exp_cnt[7:0]});
    expq.push_back(16'd4);
    @(negedge SYS_CLK);
    arm       = 1'b1;
    fifo_full = (stall > 0);
    @(negedge SYS_CLK);
    arm = 1'b0;
    check_val("ovf_clr", 32'(overflow), 32'd0);
    check_val("busy_on", 32'(busy), 32'd1);
    if (stall > 0) begin
      for (int i = 1; i <= stall; i++) begin
        check_val("stall_nowr", 32'(fifo_wr), 32'd0);
        if (i == stall) fifo_full = 1'b0;
        @(negedge SYS_CLK);
      end
      check_val("hdr_after_stall", 32'(fifo_wr), 32'd1);
    end
    repeat (2) @(negedge SYS_CLK);
    for (int i = 0; i < 4; i++) begin
      if (toggle && i == 2) begin
        @(negedge SYS_CLK);
        arm = 1'b1;
        @(negedge SYS_CLK);
        arm = 1'b0;
      end
      w = {{4{s[i][11]}}, s[i]};
      if (!drop[i]) begin
        expq.push_back(w);
        sum = sum + w;
      end
      @(negedge SYS_CLK);
      adc_data  = s[i];
      adc_valid = 1'b1;
      fifo_full = drop[i];
      @(negedge SYS_CLK);
      adc_valid = 1'b0;
      fifo_full = 1'b0;
      if (i < 3) @(negedge SYS_CLK);
    end
`ifdef CHECKSUM_EN
    expq.push_back(sum);
`endif
    ndone = 0;
    repeat (12) begin
      @(negedge SYS_CLK);
      if (done) ndone++;
    end
    exp_cnt = exp_cnt + 16'd1;
    check_val("done_once", 32'(ndone), 32'd1);
    check_val("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check_val("busy_off", 32'(busy), 32'd0);
    check_val("overflow", 32'(overflow), 32'(drop != 4'b0));
    check_val("q_drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int nd;
    reset_n   = 1'b0;
    arm       = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    fifo_full = 1'b0;
    b_arm     = 1'b0;
    b_valid   = 1'b0;
    b_data    = '0;
    b_full    = 1'b0;
    exp_cnt   = '0;
    repeat (3) @(negedge SYS_CLK);
    check_val("rst_wr", 32'(fifo_wr), 32'd0);
    check_val("rst_din", 32'(fifo_din), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_fcnt", 32'(frame_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge SYS_CLK);

    // Decimation: DECIM=3, N_SAMPLES=2, samples 10..15 keep 10 and 13.
    expq_b.push_back(16'hA500);
    expq_b.push_back(16'h0002);
    expq_b.push_back(16'h000A);
    expq_b.push_back(16'h000D);
`ifdef CHECKSUM_EN
    expq_b.push_back(16'h0017);
`endif
    @(negedge SYS_CLK);
    b_arm = 1'b1;
    @(negedge SYS_CLK);
    b_arm = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    nd = 0;
    for (int d = 10; d <= 15; d++) begin
      @(negedge SYS_CLK);
      if (b_done) nd++;
      b_data  = 12'(d);
      b_valid = 1'b1;
      @(negedge SYS_CLK);
      if (b_done) nd++;
      b_valid = 1'b0;
      @(negedge SYS_CLK);
      if (b_done) nd++;
    end
    repeat (5) begin
      @(negedge SYS_CLK);
      if (b_done) nd++;
    end
    check_val("b_done_once", 32'(nd), 32'd1);
    check_val("b_fcnt", 32'(b_fcnt), 32'd1);
    check_val("b_q_drain", 32'(expq_b.size()), 32'd0);

    // Basic frame, then a second frame with the 2nd sample dropped.
    run_frame(12'd1, 12'd2, 12'd3, 12'hFFF, 4'b0000, 0, 1'b0);
    run_frame(12'd5, 12'd6, 12'd7, 12'd8, 4'b0010, 0, 1'b0);
    // Header stalled by FIFO_FULL for 5 cycles; OVERFLOW clears on ARM.
    run_frame(12'd9, 12'h800, 12'h7FF, 12'd12, 4'b0000, 5, 1'b0);

    // Reset after two samples: no further writes, counter cleared.
    expq.push_back({8'hA5, exp_cnt[7:0]});
    expq.push_back(16'd4);
    @(negedge SYS_CLK);
    arm = 1'b1;
    @(negedge SYS_CLK);
    arm = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    for (int i = 0; i < 2; i++) begin
      expq.push_back(16'(i + 20));
      @(negedge SYS_CLK);
      adc_data  = 12'(i + 20);
      adc_valid = 1'b1;
      @(negedge SYS_CLK);
      adc_valid = 1'b0;
      @(negedge SYS_CLK);
    end
    reset_n = 1'b0;
    @(negedge SYS_CLK);
    reset_n = 1'b1;
    check_val("mid_rst_wr", 32'(fifo_wr), 32'd0);
    check_val("mid_rst_din", 32'(fifo_din), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    check_val("mid_rst_q", 32'(expq.size()), 32'd0);
    exp_cnt = '0;
    @(negedge SYS_CLK);
    adc_valid = 1'b1;
    @(negedge SYS_CLK);
    adc_valid = 1'b0;
    repeat (4) @(negedge SYS_CLK);
    run_frame(12'd1, 12'd1, 12'd1, 12'd1, 4'b0000, 0, 1'b0);

    // FRAME_CNT wrap, with an ARM pulse during the frame that must be ignored.
    @(negedge SYS_CLK);
    force dut.FRAME_CNT = 16'hFFFF;
    @(negedge SYS_CLK);
    release dut.FRAME_CNT;
    @(negedge SYS_CLK);
    check_val("fcnt_preload", 32'(frame_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    run_frame(12'd3, 12'd4, 12'hFFE, 12'd2, 4'b0000, 0, 1'b1);
    repeat (10) @(negedge SYS_CLK);
    check_val("no_extra_frame", 32'(busy), 32'd0);
    check_val("final_q", 32'(expq.size()), 32'd0);
    check_val("final_fcnt", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
